wb_frame_slave: RTL and testbench
=================================

WB_FRAME_SLAVE -- requirements
Module: wb_frame_slave

Interface
REQ-001 Parameter WB_DATA_WIDTH, default 32: bus data width; eight 4-bit pixels per row word.
REQ-002 Parameter REG_COUNT, default 8: number of row registers, one per matrix row.
REQ-003 Parameter WB_ADDR_WIDTH, default $clog2(REG_COUNT): bus address width.
REQ-004 Parameter WB_SEL_WIDTH, default WB_DATA_WIDTH/8: byte-select width.
REQ-005 Parameter STEP_CYCLES, default 16: clocks per PWM step; legal range 1 or more.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 i_wb_cyc  input  1  Wishbone cycle.
REQ-009 i_wb_stb  input  1  Wishbone strobe.
REQ-010 i_wb_we  input  1  1 = write, 0 = read.
REQ-011 i_wb_addr  input  WB_ADDR_WIDTH  row register index.
REQ-012 i_wb_sel  input  WB_SEL_WIDTH  byte enables.
REQ-013 i_wb_wdata  input  WB_DATA_WIDTH  write data.
REQ-014 o_wb_ack  output  1  transfer acknowledge.
REQ-015 o_wb_stall  output  1  pipeline stall; constant 0.
REQ-016 o_wb_rdata  output  WB_DATA_WIDTH  read data, valid while o_wb_ack is high.
REQ-017 o_row  output  REG_COUNT  one-hot active row select.
REQ-018 o_col  output  8  column drive; bit c lit when 1.
REQ-019 o_frame  output  1  one-cycle pulse when the last row completes.

Function
REQ-020 Accept condition: i_wb_cyc && i_wb_stb && !o_wb_stall; back-to-back accepts every cycle are supported.
REQ-021 Accepted write: for each set bit k of i_wb_sel, byte k of reg[i_wb_addr] takes byte k of i_wb_wdata at the edge; cleared sel bits leave the byte unchanged.
REQ-022 Accepted read: o_wb_rdata is loaded with reg[i_wb_addr] at the edge, which sets latency 1.
REQ-023 Every accept raises an internal ack flag for exactly the following cycle; o_wb_ack = flag && i_wb_cyc, so dropping cyc suppresses a pending ack.
REQ-024 Address at or above REG_COUNT: the write is discarded, a read returns 0, and ack is still given.
REQ-025 A read following a write to the same row on the next cycle returns the new data.
REQ-026 Scan counters: step_div counts 0..STEP_CYCLES-1; its wrap advances pwm 0..14; the pwm wrap advances row 0..REG_COUNT-1; the row wrap returns to 0.
REQ-027 o_frame is high for the single cycle in which row, pwm and step_div all wrap together.
REQ-028 o_row is registered as one-hot(row).
REQ-029 o_col[c] is registered as (pixel > pwm), where pixel = display row word bits [4c+3:4c]. Value 0 never lights; value 15 is always lit; value v is lit for v of the 15 steps.
REQ-030 Scan timing is independent of bus traffic; bus accesses never stall or reset the scan.

Reset
REQ-031 While reset is high: all row registers = 0, o_wb_ack = 0, o_wb_rdata = 0, counters = 0, o_row = one-hot(0), o_col = 0, o_frame = 0.
REQ-032 Reset mid-transfer drops the pending ack; no write completes in the reset cycle.
REQ-033 Scanning resumes at row 0, pwm 0 on the first edge after reset deasserts.

Configuration
REQ-034 Macro WB_FRAME_SHADOW_EN, when defined: bus writes go to a shadow bank, and reads return the shadow bank. The whole shadow bank is copied to the display bank on the o_frame cycle, so a frame is never torn. A write landing in the copy cycle appears at the next frame.
REQ-035 Macro WB_FRAME_SHADOW_EN, when undefined: a single bank is used; writes affect o_col from the next pwm evaluation cycle.

Verification
REQ-036 Write row 2 = 32'h05455450, sel = 4'hF, then read row 2: ack one cycle after each strobe; rdata = 32'h05455450.
REQ-037 Row 3 = 32'hFFFFFFFF, then write 32'h00000000 with sel = 4'b0101, then read: rdata = 32'hFF00FF00.
REQ-038 Eight back-to-back writes to rows 0..7 with cyc/stb held high: eight consecutive acks, stall = 0 throughout.
REQ-039 STEP_CYCLES = 1, row 0 = 32'h0000000F: o_col[0] high for 15 of 15 steps and o_col[7:1] = 0; o_frame period = 120 cycles.
REQ-040 Strobe accepted, then cyc dropped on the next cycle: o_wb_ack stays 0; reset asserted mid-scan: o_row = 8'h01 and o_col = 0 immediately.
REQ-041 With WB_FRAME_SHADOW_EN, write row 0 mid-frame: o_col for row 0 is unchanged until after the next o_frame pulse.

Source files
------------

// File: rtl/wb_frame_slave.sv
// wb_frame_slave: Wishbone (pipelined) slave holding one 32-bit row word per
// LED-matrix row (eight 4-bit pixels per word), plus a free-running row/PWM
// scanner that drives a one-hot row select and an 8-bit column drive.
//
// Optional feature: define WB_FRAME_SHADOW_EN to put bus writes into a shadow
// bank that is copied to the display bank on the o_frame cycle. Without it a
// single bank serves both the bus and the scanner.
//
// Handshake: a transfer is accepted in any cycle with i_wb_cyc && i_wb_stb &&
// !o_wb_stall (stall is tied low). Each accept raises an internal ack flag for
// exactly the next cycle. o_wb_ack is that flag gated by i_wb_cyc, so a
// master that drops cyc abandons its pending ack. Read data is captured at
// the accepting edge and is valid while o_wb_ack is high.
module wb_frame_slave #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int REG_COUNT     = 8,
  parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
  parameter int STEP_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
  output logic [REG_COUNT-1:0]     o_row,
  output logic [7:0]               o_col,
  output logic                     o_frame
);

  // Counter widths never drop below one bit so degenerate sizes still build.
  localparam int ROW_W  = (REG_COUNT > 1)   ? $clog2(REG_COUNT)   : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(REG_COUNT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [3:0]        PWM_LAST    = 4'd14;
  localparam logic [31:0]       REG_COUNT_U = 32'(REG_COUNT);

  // ---------------------------------------------------------------------------
  // Bus side
  // ---------------------------------------------------------------------------
  logic                     bus_accept;
  logic                     wr_accept;
  logic                     rd_accept;
  logic                     addr_hit;
  logic [ROW_W-1:0]         bus_idx;
  logic [WB_DATA_WIDTH-1:0] bus_word;
  logic [WB_DATA_WIDTH-1:0] wr_word;
  logic                     ack_q;
  logic [WB_DATA_WIDTH-1:0] rdata_q;

  // Row words seen by the scanner.
  logic [WB_DATA_WIDTH-1:0] disp_q [REG_COUNT];

`ifdef WB_FRAME_SHADOW_EN
  // Bus-facing copy; only reaches the scanner at a frame boundary.
  logic [WB_DATA_WIDTH-1:0] shadow_q [REG_COUNT];
`endif

  // Scanner state.
  logic [STEP_W-1:0]    step_q, step_d;
  logic [3:0]           pwm_q, pwm_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 step_wrap;
  logic                 pwm_wrap;
  logic                 frame_wrap;
  logic [WB_DATA_WIDTH-1:0] disp_word;
  logic [REG_COUNT-1:0] row_oh_q, row_oh_d;
  logic [7:0]           col_q, col_d;

  assign o_wb_stall = 1'b0;
  assign bus_accept = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign wr_accept  = bus_accept && i_wb_we;
  assign rd_accept  = bus_accept && !i_wb_we;

  // Addresses past the last row are acknowledged but never touch storage.
  assign addr_hit = 32'(i_wb_addr) < REG_COUNT_U;
  assign bus_idx  = ROW_W'(i_wb_addr);

`ifdef WB_FRAME_SHADOW_EN
  assign bus_word = addr_hit ? shadow_q[bus_idx] : '0;
`else
  assign bus_word = addr_hit ? disp_q[bus_idx] : '0;
`endif

  // Byte-lane merge: selected lanes take write data, the rest keep old bytes.
  always_comb begin
    wr_word = bus_word;
    for (int k = 0; k < WB_SEL_WIDTH; k++) begin
      if (i_wb_sel[k]) begin
        wr_word[8*k +: 8] = i_wb_wdata[8*k +: 8];
      end
    end
  end

  // Ack flag and read-data capture; reset drops any ack still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= bus_accept;
      if (rd_accept) begin
        rdata_q <= bus_word;
      end
    end
  end

  assign o_wb_ack   = ack_q && i_wb_cyc;
  assign o_wb_rdata = rdata_q;

`ifdef WB_FRAME_SHADOW_EN
  // Shadow bank takes bus writes; the display bank reloads from it wholesale
  // on the frame cycle. A write in that same cycle lands in the shadow after
  // the copy sampled it, so it shows up one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        shadow_q[r] <= '0;
        disp_q[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wr_accept && addr_hit && (bus_idx == ROW_W'(r))) begin
          shadow_q[r] <= wr_word;
        end
        if (frame_wrap) begin
          disp_q[r] <= shadow_q[r];
        end
      end
    end
  end
`else
  // Single bank: bus writes go straight to the words the scanner reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        disp_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wr_accept && addr_hit && (bus_idx == ROW_W'(r))) begin
          disp_q[r] <= wr_word;
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Scanner: step_div -> pwm (0..14) -> row, completely independent of the bus
  // ---------------------------------------------------------------------------

  // Next-state for the cascaded scan counters.
  always_comb begin
    step_wrap  = (step_q == STEP_LAST);
    pwm_wrap   = step_wrap && (pwm_q == PWM_LAST);
    frame_wrap = pwm_wrap && (row_q == ROW_LAST);

    step_d = step_wrap ? '0 : step_q + 1'b1;

    pwm_d = pwm_q;
    if (step_wrap) begin
      pwm_d = (pwm_q == PWM_LAST) ? 4'd0 : pwm_q + 4'd1;
    end

    row_d = row_q;
    if (pwm_wrap) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  // Column/row drive for the current (row, pwm) point. A pixel of value v is
  // lit while pwm < v, i.e. v of the 15 steps; 0 is always dark, 15 always lit.
  always_comb begin
    disp_word = disp_q[row_q];
    col_d     = '0;
    for (int c = 0; c < 8; c++) begin
      col_d[c] = disp_word[4*c +: 4] > pwm_q;
    end
    row_oh_d        = '0;
    row_oh_d[row_q] = 1'b1;
  end

  // Scan counters and registered matrix drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= '0;
      pwm_q    <= '0;
      row_q    <= '0;
      row_oh_q <= REG_COUNT'(1);
      col_q    <= '0;
    end else begin
      step_q   <= step_d;
      pwm_q    <= pwm_d;
      row_q    <= row_d;
      row_oh_q <= row_oh_d;
      col_q    <= col_d;
    end
  end

  assign o_row   = row_oh_q;
  assign o_col   = col_q;
  assign o_frame = frame_wrap;

endmodule

// File: tb/tb_wb_frame_slave.sv
// Directed bench for wb_frame_slave, built with STEP_CYCLES = 1 so one frame
// is 8 rows x 15 steps = 120 clocks. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_wb_frame_slave;

  localparam int DW = 32;
  localparam int RC = 8;
  localparam int AW = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [SW-1:0] sel;
  logic [DW-1:0] wdata;
  logic          ack, stall, frame;
  logic [DW-1:0] rdata;
  logic [RC-1:0] row;
  logic [7:0]    col;

  int errors = 0;
  int checks = 0;

  wb_frame_slave #(
    .WB_DATA_WIDTH(DW),
    .REG_COUNT(RC),
    .WB_ADDR_WIDTH(AW),
    .WB_SEL_WIDTH(SW),
    .STEP_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .i_wb_we(we),
    .i_wb_addr(addr),
    .i_wb_sel(sel),
    .i_wb_wdata(wdata),
    .o_wb_ack(ack),
    .o_wb_stall(stall),
    .o_wb_rdata(rdata),
    .o_row(row),
    .o_col(col),
    .o_frame(frame)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; sel = '0; wdata = '0;
  endtask

  // Single write: strobe one cycle, ack expected on the following cycle.
  task automatic wb_write(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d;
    @(negedge clk);
    check("wr_ack_early", 32'(ack), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("wr_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  // Single read: ack and data one cycle after the strobe.
  task automatic wb_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = '0;
    @(negedge clk);
    check({tag, "_ack_early"}, 32'(ack), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check(tag, rdata, exp);
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  // Wait (bounded) for an o_frame pulse, sampled on the falling edge.
  task automatic wait_frame(output bit found);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (frame) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  int  n;
  int  acks;
  int  r0_cycles, r0_c0, r0_other, r2_c0, r2_c4, r2_c5, fcnt, lit;
  bit  found;

  initial begin
    // Reset state.
    reset = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_rdata", rdata,      32'd0);
    check("rst_row",   32'(row),   32'h01);
    check("rst_col",   32'(col),   32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Full-word write then read back.
    wb_write(3'd2, 4'hF, 32'h05455450);
    wb_read(3'd2, 32'h05455450, "rd_row2");

    // Byte-lane write: lanes 0 and 2 cleared, lanes 1 and 3 kept.
    wb_write(3'd3, 4'hF, 32'hFFFFFFFF);
    wb_write(3'd3, 4'b0101, 32'h00000000);
    wb_read(3'd3, 32'hFF00FF00, "rd_row3_sel");

    // Never-written row reads as its reset value.
    wb_read(3'd5, 32'h00000000, "rd_row5_reset");

    // Write then read of the same row on consecutive cycles.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 3'd4; sel = 4'hF; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    we = 1'b0; sel = 4'h0;
    @(negedge clk);
    check("rw_wr_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check("rw_rd_ack", 32'(ack), 32'd1);
    check("rw_rd_data", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus_idle();

    // Eight back-to-back writes, rows 0..7, cyc/stb held high.
    acks = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      addr  = 3'(i);
      wdata = (i == 0) ? 32'h0000000F : (32'hA5A50000 | 32'(i));
      @(negedge clk);
      check("b2b_stall", 32'(stall), 32'd0);
      check("b2b_ack", 32'(ack), (i > 0) ? 32'd1 : 32'd0);
      if (ack) acks++;
      @(posedge clk); #1;
    end
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("b2b_last_ack", 32'(ack), 32'd1);
    if (ack) acks++;
    check("b2b_ack_count", 32'(acks), 32'd8);
    @(posedge clk); #1;
    bus_idle();

    wb_read(3'd7, 32'hA5A50007, "rd_row7");
    wb_read(3'd2, 32'hA5A50002, "rd_row2_b2b");

    // Frame period: 8 rows x 15 steps x 1 clock.
    wait_frame(found);
    check("frame_seen", 32'(found), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 300);
    check("frame_period", 32'(n), 32'd120);

    // One full frame of drive statistics.
    r0_cycles = 0; r0_c0 = 0; r0_other = 0;
    r2_c0 = 0; r2_c4 = 0; r2_c5 = 0; fcnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (row == 8'h01) begin
        r0_cycles++;
        if (col[0]) r0_c0++;
        if (col[7:1] != 7'd0) r0_other++;
      end
      if (row == 8'h04) begin
        if (col[0]) r2_c0++;
        if (col[4]) r2_c4++;
        if (col[5]) r2_c5++;
      end
      if (frame) fcnt++;
    end
    check("row0_cycles",   32'(r0_cycles), 32'd15);
    check("row0_col0_lit", 32'(r0_c0),     32'd15);
    check("row0_col71",    32'(r0_other),  32'd0);
    check("row2_col0_lit", 32'(r2_c0),     32'd2);
    check("row2_col4_lit", 32'(r2_c4),     32'd5);
    check("row2_col5_lit", 32'(r2_c5),     32'd10);
    check("frames_in_win", 32'(fcnt),      32'd1);

    // Clear row 0 right after a frame pulse, while row 0 is being scanned.
    // Single bank: the old value drives only the cycle before the write
    // lands. Shadow bank: the old value holds for the whole frame.
    wait_frame(found);
    check("frame_seen2", 32'(found), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 3'd0; sel = 4'hF; wdata = 32'h0;
    lit = 0; fcnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (row == 8'h01 && col[0]) lit++;
      if (frame) fcnt++;
      if (i == 1) begin stb = 1'b0; we = 1'b0; end
      if (i == 2) cyc = 1'b0;
    end
`ifdef WB_FRAME_SHADOW_EN
    check("upd_lit_same_frame", 32'(lit), 32'd15);
`else
    check("upd_lit_same_frame", 32'(lit), 32'd1);
`endif
    check("upd_frames", 32'(fcnt), 32'd1);
    bus_idle();
    lit = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (row == 8'h01 && col[0]) lit++;
    end
    check("upd_lit_next_frame", 32'(lit), 32'd0);

    // Strobe accepted, then cyc dropped: no ack.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd2;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("cycdrop_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("cycdrop_ack2", 32'(ack), 32'd0);

    // Restore a lit pixel, then reset mid-scan with a read ack pending.
    wb_write(3'd3, 4'hF, 32'hFFFFFFFF);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (row == 8'h10) begin found = 1'b1; break; end
    end
    check("reach_row4", 32'(found), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd3;
    @(posedge clk); #1;
    stb = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ack",   32'(ack),   32'd0);
    check("midrst_row",   32'(row),   32'h01);
    check("midrst_col",   32'(col),   32'd0);
    check("midrst_rdata", rdata,      32'd0);
    check("midrst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset = 1'b0;

    // Scan restarts at row 0: 15 steps on row 0, then row 1.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("resume_row", 32'(row), (i < 15) ? 32'h01 : 32'h02);
    end

    // Storage cleared by the reset.
    wb_read(3'd3, 32'h00000000, "rd_row3_after_rst");
    wb_read(3'd0, 32'h00000000, "rd_row0_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
